// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage 8-bit CPU: RAW interlock by stalling,
// control-flow flushes, mid-cycle RF/LR write strobes and stall/flush stats.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_ins,
    input  logic [15:0]      exe_ins,
    input  logic [15:0]      dm_ins,
    input  logic [15:0]      wb_ins,
    input  logic             exe_branch_taken,
    output logic             pc_we,
    output logic             pc_redirect,
    output logic             ifid_hold,
    output logic             ifid_bubble_en,
    output logic             idexe_bubble,
    output logic             rf_we,
    output logic             lr_we,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t cur, nxt;

    logic [3:0] id_op, exe_op, dm_op;
    logic [1:0] id_rd, id_rs1, id_rs2, exe_rd, dm_rd;
    logic       exe_w, dm_w, hazard, redirect;
    logic       wb_wr_q, call_q;
    logic [15:0] wb_unused;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h8);
    endfunction

    function automatic logic hit(
        input logic [1:0] r,
        input logic       ew,
        input logic [1:0] erd,
        input logic       dw,
        input logic [1:0] drd
    );
        return (ew && (erd == r)) || (dw && (drd == r));
    endfunction

    assign id_op  = id_ins[15:12];
    assign id_rd  = id_ins[11:10];
    assign id_rs1 = id_ins[9:8];
    assign id_rs2 = id_ins[7:6];
    assign exe_op = exe_ins[15:12];
    assign exe_rd = exe_ins[11:10];
    assign dm_op  = dm_ins[15:12];
    assign dm_rd  = dm_ins[11:10];
    assign exe_w  = writes_rd(exe_op);
    assign dm_w   = writes_rd(dm_op);
    // WB writers complete before ID reads, so wb_ins never interlocks.
    assign wb_unused = wb_ins;

    // Detect RAW hazards of the ID reader against EXE/DM writers and redirects.
    always_comb begin
        hazard   = 1'b0;
        redirect = 1'b0;
        unique case (1'b1)
            (id_op >= 4'h1) && (id_op <= 4'h7):
                hazard = hit(id_rs1, exe_w, exe_rd, dm_w, dm_rd)
                       | hit(id_rs2, exe_w, exe_rd, dm_w, dm_rd);
            id_op == 4'h8:
                hazard = hit(id_rs1, exe_w, exe_rd, dm_w, dm_rd);
            (id_op == 4'h9) || (id_op == 4'hA):
                hazard = hit(id_rs1, exe_w, exe_rd, dm_w, dm_rd)
                       | hit(id_rd, exe_w, exe_rd, dm_w, dm_rd);
            default: hazard = 1'b0;
        endcase
        redirect = (exe_op == 4'hB) || (exe_op == 4'hC) || (exe_op == 4'hD)
                 || ((exe_op == 4'hA) && exe_branch_taken);
    end

    // Drive pipeline controls; a redirect wins since ID is wrong-path.
    always_comb begin
        pc_we          = 1'b0;
        pc_redirect    = 1'b0;
        ifid_hold      = 1'b0;
        ifid_bubble_en = 1'b0;
        idexe_bubble   = 1'b0;
        if (!rst) begin
            pc_we          = redirect || !hazard;
            pc_redirect    = redirect;
            ifid_hold      = hazard && !redirect;
            ifid_bubble_en = redirect;
            idexe_bubble   = redirect || hazard;
        end
    end

    // Next-state: record this cycle's classification.
    always_comb begin
        nxt = cur;
        unique case (cur)
            RUN:     nxt = redirect ? FLUSH : (hazard ? STALL : RUN);
            STALL:   nxt = redirect ? FLUSH : (hazard ? STALL : RUN);
            FLUSH:   nxt = redirect ? FLUSH : (hazard ? STALL : RUN);
            default: nxt = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= RUN;
        else     cur <= nxt;
    end

    assign state = cur;

    // Remember writers entering WB and CALLs entering DM for the strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wr_q <= 1'b0;
            call_q  <= 1'b0;
        end else begin
            wb_wr_q <= dm_w;
            call_q  <= (exe_op == 4'hC);
        end
    end

    // Strobes rise at mid-cycle, so back-to-back writers give distinct edges.
    assign rf_we = wb_wr_q & ~clk;
    assign lr_we = call_q & ~clk;

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && !redirect && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
